// File: rtl/rf_2p_arb.sv
// rf_2p_arb: round-robin arbiter in front of a 1W/1R register file.
// Each port has its own rotating pointer; reads return one cycle later, with a write-first bypass.
module rf_2p_arb #(
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int AWD    = $clog2(WORDWD),
    parameter int NREQ   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_wvalid,
    input  logic [AWD-1:0]  i_waddr [NREQ],
    input  logic [DWD-1:0]  i_wdata [NREQ],
    output logic [NREQ-1:0] o_wready,
    input  logic [NREQ-1:0] i_rvalid,
    input  logic [AWD-1:0]  i_raddr [NREQ],
    output logic [NREQ-1:0] o_rready,
    output logic [NREQ-1:0] o_rdvalid,
    output logic [DWD-1:0]  o_rdata,
    output logic            o_rderr,
    output logic            o_rf_write,
    output logic [AWD-1:0]  o_rf_waddr,
    output logic [DWD-1:0]  o_rf_wdata,
    output logic            o_rf_read,
    output logic [AWD-1:0]  o_rf_raddr,
    input  logic [DWD-1:0]  i_rf_rdata
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

    logic [PW-1:0]  wptr, rptr, wg, rg;
    logic           wg_v, rg_v, w_in, r_in;
    logic [NREQ-1:0] rdv;
    logic           rd_err, rd_byp;
    logic [DWD-1:0] byp_data;

    // Returns {found, index} of the first valid at or above the pointer, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] p);
        logic [PW:0] r;
        int k;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(p) + i) % NREQ;
            if (v[PW'(k)]) r = {1'b1, PW'(k)};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] g);
        return (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
    endfunction

    always_comb begin
        {wg_v, wg} = i_rst ? rr_pick(i_wvalid, wptr) : '0;
        {rg_v, rg} = i_rst ? rr_pick(i_rvalid, rptr) : '0;
        o_wready   = wg_v ? NREQ'(1) << wg : '0;
        o_rready   = rg_v ? NREQ'(1) << rg : '0;
        w_in       = wg_v && int'(i_waddr[wg]) < WORDWD;
        r_in       = rg_v && int'(i_raddr[rg]) < WORDWD;
        o_rf_write = w_in;
        o_rf_waddr = w_in ? i_waddr[wg] : '0;
        o_rf_wdata = w_in ? i_wdata[wg] : '0;
        o_rf_read  = r_in;
        o_rf_raddr = r_in ? i_raddr[rg] : '0;
        o_rdvalid  = rdv;
        o_rderr    = |rdv & rd_err;
        o_rdata    = (|rdv && !rd_err) ? (rd_byp ? byp_data : i_rf_rdata) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            rdv      <= '0;
            rd_err   <= 1'b0;
            rd_byp   <= 1'b0;
            byp_data <= '0;
        end else begin
            if (wg_v) wptr <= nxt(wg);
            if (rg_v) rptr <= nxt(rg);
            rdv      <= o_rready;
            rd_err   <= rg_v && !r_in;
            // Same-address write in the read's cycle wins over the stale RF data.
            rd_byp   <= r_in && w_in && i_raddr[rg] == i_waddr[wg];
            byp_data <= w_in ? i_wdata[wg] : '0;
        end
    end
endmodule

// File: tb/tb_rf_2p_arb.sv
// tb_rf_2p_arb: scoreboard bench for rf_2p_arb with a behavioural RF behind it.
module tb_rf_2p_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wvalid = '0, rvalid = '0;
    logic [3:0]  waddr [2] = '{default: '0};
    logic [3:0]  raddr [2] = '{default: '0};
    logic [15:0] wdata [2] = '{default: '0};
    logic [1:0]  wready, rready, rdvalid;
    logic [15:0] rdata, rf_wdata;
    logic [15:0] rf_rdata = '0;
    logic        rderr, rf_write, rf_read;
    logic [3:0]  rf_waddr, rf_raddr;

    logic [15:0] mem [16] = '{default: '0};
    logic [15:0] sh [16] = '{default: '0};
    int errors = 0, checks = 0, nret = 0;
    int exp_wptr = 0, exp_rptr = 0;
    logic [1:0]  exp_wready, exp_rready;
    logic        exp_rf_write, exp_rf_read;
    logic [3:0]  exp_waddr, exp_raddr;
    logic [15:0] exp_wdata;

    typedef struct {int g; logic [15:0] d; logic e;} ret_t;
    ret_t sb[$];
    ret_t e;

    always #5 clk = ~clk;

    rf_2p_arb dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_wvalid(wvalid), .i_waddr(waddr), .i_wdata(wdata), .o_wready(wready),
        .i_rvalid(rvalid), .i_raddr(raddr), .o_rready(rready),
        .o_rdvalid(rdvalid), .o_rdata(rdata), .o_rderr(rderr),
        .o_rf_write(rf_write), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .o_rf_read(rf_read), .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata)
    );

    // Registered-output RF: reads see the contents before a same-edge write.
    always @(posedge clk) begin
        if (rf_write) mem[rf_waddr] <= rf_wdata;
        if (rf_read) rf_rdata <= mem[rf_raddr];
    end

    always @(negedge clk) begin
        checks++;
        if (rdvalid !== 2'b00) begin
            nret++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_return rdvalid=%b rdata=%h", rdvalid, rdata);
            end else begin
                e = sb.pop_front();
                if (rdvalid !== 2'(2'b01 << e.g) || rdata !== e.d || rderr !== e.e) begin
                    errors++;
                    $display("FAIL return got rdvalid=%b rdata=%h rderr=%b want rdvalid=%b rdata=%h rderr=%b",
                             rdvalid, rdata, rderr, 2'(2'b01 << e.g), e.d, e.e);
                end
            end
        end else if (rdata !== 16'h0 || rderr !== 1'b0) begin
            errors++;
            $display("FAIL idle_return got rdata=%h rderr=%b want 0 0", rdata, rderr);
        end
    end

    function automatic int pick(input logic [1:0] v, input int p);
        for (int i = 0; i < 2; i++) if (v[(p + i) % 2]) return (p + i) % 2;
        return -1;
    endfunction

    task automatic drive(input logic [1:0] wv, input logic [3:0] wa0, wa1, input logic [15:0] wd0, wd1,
                         input logic [1:0] rv, input logic [3:0] ra0, ra1);
        int wgi, rgi;
        wvalid = wv; waddr[0] = wa0; waddr[1] = wa1; wdata[0] = wd0; wdata[1] = wd1;
        rvalid = rv; raddr[0] = ra0; raddr[1] = ra1;
        wgi = pick(wv, exp_wptr);
        rgi = pick(rv, exp_rptr);
        exp_wready = wgi < 0 ? 2'b00 : 2'(2'b01 << wgi);
        exp_rready = rgi < 0 ? 2'b00 : 2'(2'b01 << rgi);
        exp_rf_write = 1'b0; exp_waddr = '0; exp_wdata = '0;
        exp_rf_read = 1'b0; exp_raddr = '0;
        if (wgi >= 0) begin
            exp_wptr = (wgi + 1) % 2;
            if (waddr[wgi] < 12) begin
                exp_rf_write = 1'b1; exp_waddr = waddr[wgi]; exp_wdata = wdata[wgi];
                sh[exp_waddr] = exp_wdata;
            end
        end
        if (rgi >= 0) begin
            exp_rptr = (rgi + 1) % 2;
            if (raddr[rgi] < 12) begin
                exp_rf_read = 1'b1; exp_raddr = raddr[rgi];
            end
            sb.push_back('{rgi, exp_rf_read ? sh[raddr[rgi]] : 16'h0, !exp_rf_read});
        end
    endtask

    task automatic idle();
        drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 4'd0, 4'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wvalid = 2'b11; rvalid = 2'b11; waddr[0] = 4'd1; raddr[0] = 4'd1;
        repeat (2) @(negedge clk);
        checks++;
        if (wready !== 2'b00 || rready !== 2'b00 || rf_write !== 1'b0 || rf_read !== 1'b0 || rdvalid !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs got wready=%b rready=%b rf_write=%b rf_read=%b rdvalid=%b want all 0",
                     wready, rready, rf_write, rf_read, rdvalid);
        end
        tick();
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_write_rr();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 4'd8, 4'd9, 16'hA000, 16'hA001, 2'b00, 4'd0, 4'd0);
            @(negedge clk);
            checks++;
            if (wready !== 2'(2'b01 << (i % 2)) || rf_write !== 1'b1 || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL write_rr[%0d] got wready=%b waddr=%0d wdata=%h want wready=%b waddr=%0d wdata=%h",
                         i, wready, rf_waddr, rf_wdata, 2'(2'b01 << (i % 2)), exp_waddr, exp_wdata);
            end
            tick();
        end
    endtask

    task automatic test_read_return();
        drive(2'b01, 4'd5, 4'd0, 16'hBEEF, 16'h0, 2'b00, 4'd0, 4'd0);
        @(negedge clk);
        checks++;
        if (rf_write !== 1'b1 || rf_waddr !== 4'd5 || rf_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_5 got en=%b addr=%0d data=%h want 1 5 beef", rf_write, rf_waddr, rf_wdata);
        end
        tick();
        drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b10, 4'd0, 4'd5);
        @(negedge clk);
        checks++;
        if (rf_read !== 1'b1 || rf_raddr !== 4'd5 || rready !== 2'b10) begin
            errors++;
            $display("FAIL read_5_issue got rf_read=%b raddr=%0d rready=%b want 1 5 10", rf_read, rf_raddr, rready);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rdvalid !== 2'b10 || rdata !== 16'hBEEF || rderr !== 1'b0) begin
            errors++;
            $display("FAIL read_5_return got rdvalid=%b rdata=%h rderr=%b want 10 beef 0", rdvalid, rdata, rderr);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(2'b01, 4'd3, 4'd0, 16'h1234, 16'h0, 2'b01, 4'd3, 4'd0);
        @(negedge clk);
        checks++;
        if (rf_write !== 1'b1 || rf_read !== 1'b1 || rf_raddr !== 4'd3) begin
            errors++;
            $display("FAIL bypass_issue got rf_write=%b rf_read=%b raddr=%0d want 1 1 3", rf_write, rf_read, rf_raddr);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rdvalid !== 2'b01 || rdata !== 16'h1234 || rderr !== 1'b0) begin
            errors++;
            $display("FAIL bypass_return got rdvalid=%b rdata=%h rderr=%b want 01 1234 0", rdvalid, rdata, rderr);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        drive(2'b01, 4'd12, 4'd0, 16'hDEAD, 16'h0, 2'b01, 4'd13, 4'd0);
        @(negedge clk);
        checks++;
        if (rf_write !== 1'b0 || rf_read !== 1'b0 || wready !== 2'b01 || rready !== 2'b01 ||
            rf_waddr !== 4'd0 || rf_wdata !== 16'h0 || rf_raddr !== 4'd0) begin
            errors++;
            $display("FAIL oor_issue got rf_write=%b rf_read=%b wready=%b rready=%b waddr=%0d wdata=%h raddr=%0d want 0 0 01 01 0 0 0",
                     rf_write, rf_read, wready, rready, rf_waddr, rf_wdata, rf_raddr);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rdvalid !== 2'b01 || rdata !== 16'h0 || rderr !== 1'b1) begin
            errors++;
            $display("FAIL oor_return got rdvalid=%b rdata=%h rderr=%b want 01 0000 1", rdvalid, rdata, rderr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = nret;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b11, 4'd8, 4'd9);
            else idle();
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (rdvalid === 2'b00) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d] got rdvalid=%b want a return", i, rdvalid);
                end
            end
            tick();
        end
        checks++;
        if (nret - n0 != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d returns, %0d pending want 8 returns, 0 pending", nret - n0, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b01, 4'd5, 4'd0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_wptr = 0;
        exp_rptr = 0;
        @(negedge clk);
        checks++;
        if (rready !== 2'b00 || rdvalid !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_hold got rready=%b rdvalid=%b want 00 00", rready, rdvalid);
        end
        tick();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdvalid !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_release got rdvalid=%b want 00", rdvalid);
        end
        tick();
        drive(2'b11, 4'd8, 4'd9, 16'hA000, 16'hA001, 2'b11, 4'd8, 4'd9);
        @(negedge clk);
        checks++;
        if (wready !== 2'b01 || rready !== 2'b01) begin
            errors++;
            $display("FAIL ptr_after_reset got wready=%b rready=%b want 01 01", wready, rready);
        end
        tick();
        idle();
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_write_rr();
        test_read_return();
        test_bypass();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
